seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Sequential radix-2 restoring divider. It is the inverse operation of the team's combinational Booth multiplier.
- Takes a WIDTH-bit dividend and divisor and produces quotient and remainder, one quotient bit per clock.
- Sits beside the multiplier in the arithmetic datapath and uses a start/done handshake toward the controlling FSM.

Parameters:
WIDTH, 6, operand/result width in bits (>= 2)
CNT_W, 3, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  request; sampled only in IDLE
in1  input  WIDTH  dividend
in2  input  WIDTH  divisor
busy  output  1  high in CALC and DONE
done  output  1  one-cycle pulse, results valid
quot  output  WIDTH  quotient
rem  output  WIDTH  remainder
div_zero  output  1  divisor was zero for the latched operation

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-low.
  - On a clk edge with rst_n=0: state=IDLE, busy=0, done=0, quot=0, rem=0, div_zero=0, internal registers cleared.
  - Reset mid-operation aborts the division; no done pulse is produced for it.
- State machine, IDLE -> CALC -> DONE -> IDLE:
  - IDLE, start=1, in2!=0: latch operands, count=0, go to CALC.
  - IDLE, start=1, in2==0: go directly to DONE with quot = all ones, rem = in1, div_zero=1.
  - CALC: one iteration per edge. Shift {partial remainder, dividend magnitude} left 1. Trial-subtract the divisor magnitude in WIDTH+1 bits. If the result is non-negative, keep it and shift in a quotient bit of 1; otherwise restore and shift in 0. count increments each iteration.
  - CALC exit: after iteration WIDTH (count==WIDTH-1), apply sign correction, register quot and rem, div_zero=0, go to DONE.
  - DONE: done=1 for exactly this one cycle, then go to IDLE.
- Latency:
  - Nonzero divisor: done is asserted in the cycle starting WIDTH+1 edges after the edge that accepted start (7 for WIDTH=6).
  - Zero divisor: done is asserted 1 edge after acceptance.
- Handshake:
  - start while busy=1 is ignored; no queuing.
  - start held high in IDLE right after DONE begins a new operation using the operands present on that edge.
  - in1/in2 may change freely after acceptance.
- Outputs:
  - quot, rem and div_zero hold their values from done until the next done or reset.
  - They are not cleared by a new start.
- Arithmetic (signed mode):
  - Operands are two's complement. Magnitudes are taken in WIDTH+1 bits, so -2^(WIDTH-1) is handled.
  - Quotient truncates toward zero; it is negated when the operand signs differ.
  - Remainder takes the dividend's sign; |rem| < |divisor|.
  - -2^(WIDTH-1) / -1 wraps to -2^(WIDTH-1) with rem=0; no overflow flag.

Optional Feature:
- Macro: DIV_SIGNED_EN.
- Defined: signed two's-complement division as described in Behaviour.
- Undefined:
  - in1/in2 are unsigned; the magnitude stage and sign correction are removed.
  - Latency is unchanged.
  - Zero divisor still gives quot = all ones, rem = in1, div_zero=1.

Test Plan:
- Signed, reset then start with in1=27, in2=5 -> done exactly 7 cycles after acceptance; quot=5 (6'b000101), rem=2, div_zero=0.
- Signed, in1=-27 (6'b100101), in2=5 -> quot=-5 (6'b111011), rem=-2 (6'b111110). Also in1=27, in2=-5 -> quot=6'b111011, rem=2.
- in1=13, in2=0 -> done 1 cycle after acceptance; quot=6'b111111, rem=13, div_zero=1. Next op 12/4 -> quot=3, rem=0, div_zero=0.
- Signed, in1=-32 (6'b100000), in2=-1 -> quot=6'b100000, rem=0. Unsigned build, in1=63, in2=4 -> quot=15, rem=3.
- Start 20/3; pulse start with 9/2 on cycle 3 while busy -> ignored; single done with quot=6, rem=2. busy is high across CALC+DONE.
- Start 20/3; drive rst_n=0 on cycle 4 -> next edge busy=0, done=0, quot=0, rem=0. No done follows; a fresh 20/3 completes normally.

Source files
------------

// File: rtl/seq_divider.sv
// Sequential radix-2 restoring divider: one quotient bit per clock, start/done handshake.
// Define DIV_SIGNED_EN for two's-complement operands; the default build divides unsigned values.
module seq_divider #(
    parameter int WIDTH = 6,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             div_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] count;
    logic [WIDTH:0]   prem;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH:0]   dvs;

    logic [WIDTH-1:0] in1_mag;
    logic [WIDTH:0]   in2_mag;
    logic [WIDTH+1:0] r_sh;
    logic [WIDTH+1:0] trial;
    logic             q_bit;
    logic [WIDTH:0]   prem_nx;
    logic [WIDTH-1:0] dvd_nx;

`ifdef DIV_SIGNED_EN
    logic             neg_q;
    logic             neg_r;
    logic [WIDTH:0]   in2_ext;

    // Divisor magnitude needs WIDTH+1 bits so the most negative value survives negation.
    assign in2_ext = {in2[WIDTH-1], in2};
    assign in1_mag = in1[WIDTH-1] ? (~in1 + 1'b1) : in1;
    assign in2_mag = in2[WIDTH-1] ? (~in2_ext + 1'b1) : in2_ext;
`else
    assign in1_mag = in1;
    assign in2_mag = {1'b0, in2};
`endif

    // The extra top bit of r_sh/trial is the borrow; a set sign bit means restore.
    assign r_sh    = {prem, dvd[WIDTH-1]};
    assign trial   = r_sh - {1'b0, dvs};
    assign q_bit   = ~trial[WIDTH+1];
    assign prem_nx = q_bit ? trial[WIDTH:0] : r_sh[WIDTH:0];
    assign dvd_nx  = {dvd[WIDTH-2:0], q_bit};

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (in2 == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (count == LAST) begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count    <= '0;
            prem     <= '0;
            dvd      <= '0;
            dvs      <= '0;
            quot     <= '0;
            rem      <= '0;
            div_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (in2 == '0) begin
                            quot     <= '1;
                            rem      <= in1;
                            div_zero <= 1'b1;
                        end else begin
                            prem  <= '0;
                            dvd   <= in1_mag;
                            dvs   <= in2_mag;
                            count <= '0;
`ifdef DIV_SIGNED_EN
                            neg_q <= in1[WIDTH-1] ^ in2[WIDTH-1];
                            neg_r <= in1[WIDTH-1];
`endif
                        end
                    end
                end
                CALC: begin
                    prem  <= prem_nx;
                    dvd   <= dvd_nx;
                    count <= count + 1'b1;
                    if (count == LAST) begin
`ifdef DIV_SIGNED_EN
                        quot <= neg_q ? (~dvd_nx + 1'b1) : dvd_nx;
                        rem  <= neg_r ? (~prem_nx[WIDTH-1:0] + 1'b1) : prem_nx[WIDTH-1:0];
`else
                        quot <= dvd_nx;
                        rem  <= prem_nx[WIDTH-1:0];
`endif
                        div_zero <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases, handshake corner cases and
// randomized operations scored against a plain-arithmetic reference model.
module tb_seq_divider;

    localparam int W = 6;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic         busy;
    logic         done;
    logic [W-1:0] quot;
    logic [W-1:0] rem;
    logic         div_zero;

    int errors = 0;
    int checks = 0;

    logic [2*W:0] exp_q[$];

    seq_divider #(.WIDTH(W), .CNT_W(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in1      (in1),
        .in2      (in2),
        .busy     (busy),
        .done     (done),
        .quot     (quot),
        .rem      (rem),
        .div_zero (div_zero)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // Packs {quotient, remainder, div_zero}.
    function automatic logic [2*W:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
        int sa;
        int sb;
        int q;
        int r;
        if (b == '0) return {{W{1'b1}}, a, 1'b1};
        sa = int'(a);
        sb = int'(b);
`ifdef DIV_SIGNED_EN
        if (a[W-1]) sa = sa - (1 << W);
        if (b[W-1]) sb = sb - (1 << W);
`endif
        q = sa / sb;
        r = sa % sb;
        return {q[W-1:0], r[W-1:0], 1'b0};
    endfunction

    function automatic int exp_lat(input logic [W-1:0] b);
        return (b == '0) ? 1 : W + 1;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    // lat counts edges from the accepting edge (inclusive) until done is seen.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output logic got);
        wait_idle();
        in1   = a;
        in2   = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        in1   = W'($urandom);
        in2   = W'($urandom);
        lat   = 1;
        while (!done && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
        end
        got = done;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        in1   = '0;
        in2   = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, quot, rem, div_zero} !== '0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b quot=%h rem=%h dz=%b, want all 0",
                     busy, done, quot, rem, div_zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [W-1:0] ta[6];
        logic [W-1:0] tb[6];
        logic [W-1:0] tq[6];
        logic [W-1:0] tr[6];
        int           lat;
        logic         got;
`ifdef DIV_SIGNED_EN
        ta = '{6'd27, 6'b100101, 6'd27,     6'd13,     6'd12, 6'b100000};
        tb = '{6'd5,  6'd5,      6'b111011, 6'd0,      6'd4,  6'b111111};
        tq = '{6'd5,  6'b111011, 6'b111011, 6'b111111, 6'd3,  6'b100000};
        tr = '{6'd2,  6'b111110, 6'd2,      6'd13,     6'd0,  6'd0};
`else
        ta = '{6'd27, 6'd37, 6'd63, 6'd13,     6'd12, 6'd32};
        tb = '{6'd5,  6'd5,  6'd4,  6'd0,      6'd4,  6'd63};
        tq = '{6'd5,  6'd7,  6'd15, 6'b111111, 6'd3,  6'd0};
        tr = '{6'd2,  6'd2,  6'd3,  6'd13,     6'd0,  6'd32};
`endif
        for (int i = 0; i < 6; i++) begin
            run_op(ta[i], tb[i], lat, got);
            checks++;
            if (got !== 1'b1 || lat != ((tb[i] == '0) ? 1 : 7)) begin
                errors++;
                $display("FAIL directed[%0d] latency: got done=%b after %0d edges, want %0d",
                         i, got, lat, (tb[i] == '0) ? 1 : 7);
            end
            checks++;
            if (quot !== tq[i]) begin
                errors++;
                $display("FAIL directed[%0d] quot: got %b want %b", i, quot, tq[i]);
            end
            checks++;
            if (rem !== tr[i]) begin
                errors++;
                $display("FAIL directed[%0d] rem: got %b want %b", i, rem, tr[i]);
            end
            checks++;
            if (div_zero !== (tb[i] == '0)) begin
                errors++;
                $display("FAIL directed[%0d] div_zero: got %b want %b", i, div_zero, tb[i] == '0);
            end
            @(posedge clk);
            #1;
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL directed[%0d] done pulse: done=%b one cycle later, want 0", i, done);
            end
        end
    endtask

    task automatic test_busy_ignore();
        int ndone;
        wait_idle();
        in1   = 6'd20;
        in2   = 6'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0;
        for (int c = 1; c <= 20; c++) begin
            if (c == 3) begin
                in1   = 6'd9;
                in2   = 6'd2;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (c <= W + 1) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_high: edge %0d busy=%b want 1", c, busy);
                end
            end
            if (c == W + 2) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_low: edge %0d busy=%b want 0", c, busy);
                end
            end
            if (done === 1'b1) begin
                ndone++;
                checks++;
                if (c != W + 1 || quot !== 6'd6 || rem !== 6'd2) begin
                    errors++;
                    $display("FAIL busy_ignore result: edge %0d quot=%0d rem=%0d, want edge 7 quot=6 rem=2",
                             c, quot, rem);
                end
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (ndone != 1) begin
            errors++;
            $display("FAIL busy_ignore done count: got %0d want 1", ndone);
        end
    endtask

    task automatic test_reset_mid();
        int   ndone;
        int   lat;
        logic got;
        wait_idle();
        in1   = 6'd20;
        in2   = 6'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({busy, done, quot, rem} !== '0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b done=%b quot=%h rem=%h, want all 0", busy, done, quot, rem);
        end
        rst_n = 1'b1;
        ndone = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) ndone++;
        end
        checks++;
        if (ndone != 0) begin
            errors++;
            $display("FAIL reset_mid stray done: got %0d pulses want 0", ndone);
        end
        run_op(6'd20, 6'd3, lat, got);
        checks++;
        if (got !== 1'b1 || lat != W + 1 || quot !== 6'd6 || rem !== 6'd2 || div_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid rerun: done=%b lat=%0d quot=%0d rem=%0d dz=%b, want 1 7 6 2 0",
                     got, lat, quot, rem, div_zero);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a1, b1, a2, b2;
        logic [2*W:0] e;
        int           lat;
        a1 = W'($urandom);
        b1 = W'($urandom_range(1, (1 << W) - 1));
        a2 = W'($urandom);
        b2 = W'($urandom_range(1, (1 << W) - 1));
        wait_idle();
        in1   = a1;
        in2   = b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        lat = 1;
        while (!done && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
        end
        e = ref_div(a1, b1);
        checks++;
        if (lat != W + 1 || {quot, rem, div_zero} !== e) begin
            errors++;
            $display("FAIL b2b first %0d/%0d: lat=%0d q=%h r=%h dz=%b, want lat=%0d q=%h r=%h dz=%b",
                     a1, b1, lat, quot, rem, div_zero, W + 1, e[2*W:W+1], e[W:1], e[0]);
        end
        in1 = a2;
        in2 = b2;
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b idle gap: done=%b busy=%b want 0 0", done, busy);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b accept: busy=%b want 1", busy);
        end
        while (!done && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
        end
        e = ref_div(a2, b2);
        checks++;
        if (lat != W + 1 || {quot, rem, div_zero} !== e) begin
            errors++;
            $display("FAIL b2b second %0d/%0d: lat=%0d q=%h r=%h dz=%b, want lat=%0d q=%h r=%h dz=%b",
                     a2, b2, lat, quot, rem, div_zero, W + 1, e[2*W:W+1], e[W:1], e[0]);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        logic [2*W:0] e;
        int           lat;
        logic         got;
        for (int i = 0; i < 40; i++) begin
            a = W'($urandom);
            b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            if (i == 0) begin
                a = {1'b1, {(W-1){1'b0}}};
                b = '1;
            end
            exp_q.push_back(ref_div(a, b));
            run_op(a, b, lat, got);
            e = exp_q.pop_front();
            checks++;
            if (got !== 1'b1 || lat != exp_lat(b)) begin
                errors++;
                $display("FAIL random[%0d] latency %0d/%0d: done=%b lat=%0d want %0d",
                         i, a, b, got, lat, exp_lat(b));
            end
            checks++;
            if ({quot, rem, div_zero} !== e) begin
                errors++;
                $display("FAIL random[%0d] result %h/%h: q=%h r=%h dz=%b, want q=%h r=%h dz=%b",
                         i, a, b, quot, rem, div_zero, e[2*W:W+1], e[W:1], e[0]);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        in1   = '0;
        in2   = '0;
        test_reset();
        test_directed();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
